// File: rtl/midway8080_vram_pkg.sv
// Shared constants, op codes, FSM state type and bit-update helper for the
// Midway 8080 VRAM pixel path (toggle op enabled by MIDWAY8080_VRAM_TOGGLE_EN).
package midway8080_vram_pkg;

   localparam int ADDR_W     = 13;
   localparam int VRAM_BYTES = 7168;
   localparam int X_LIMIT    = 224;

   localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(VRAM_BYTES - 1);
   localparam logic [ADDR_W-1:0] PENULT_ADDR = ADDR_W'(VRAM_BYTES - 2);

   localparam logic [1:0] OP_CLR = 2'b00;
   localparam logic [1:0] OP_SET = 2'b01;
   localparam logic [1:0] OP_TOG = 2'b10;
   localparam logic [1:0] OP_RSV = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_READ,
      ST_CAPTURE,
      ST_WRITE,
      ST_REJECT,
      ST_CLEAR
   } state_e;

   // Returns the byte with only bit idx cleared, set or inverted.
   function automatic logic [7:0] apply_op(input logic [7:0] b,
                                           input logic [2:0] idx,
                                           input logic [1:0] op);
      logic [7:0] m;
      m = 8'h01 << idx;
      case (op)
         OP_CLR: apply_op = b & ~m;
         OP_SET: apply_op = b | m;
         OP_TOG: apply_op = b ^ m;
         OP_RSV: apply_op = b;
      endcase
   endfunction

endpackage

// File: rtl/midway8080_vram_addr_map.sv
// Combinational pixel-to-VRAM mapping; the display reader uses the same module
// so the two sides can never drift apart.
module midway8080_vram_addr_map
   import midway8080_vram_pkg::*;
(
   input  logic [7:0]        x_i,
   input  logic [7:0]        y_i,
   output logic [ADDR_W-1:0] addr_o,
   output logic [2:0]        bit_o,
   output logic              in_range_o
);

   // Rows run bottom-up inside each 32-byte column, MSB first within a byte.
   assign addr_o     = {x_i, 5'd31 - y_i[7:3]};
   assign bit_o      = 3'd7 - y_i[2:0];
   assign in_range_o = (x_i < 8'(X_LIMIT));

endmodule

// File: rtl/midway8080_vram_pixel_writer.sv
// Read-modify-write pixel writer and full-screen clearer for the Midway 8080 VRAM.
// Define MIDWAY8080_VRAM_TOGGLE_EN to make op 10 invert a bit instead of rejecting it.
module midway8080_vram_pixel_writer
   import midway8080_vram_pkg::*;
(
   input  logic        clk,
   input  logic        resetn,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [7:0]  req_x,
   input  logic [7:0]  req_y,
   input  logic [1:0]  req_op,
   input  logic        clear_start,
   output logic [12:0] mem_addr,
   output logic        mem_rden,
   input  logic [7:0]  mem_rdata,
   output logic        mem_wren,
   output logic [7:0]  mem_wdata,
   output logic        done,
   output logic        err,
   output logic        busy
);

   state_e            state_q;
   logic [ADDR_W-1:0] addr_q;
   logic [2:0]        bit_q;
   logic [1:0]        op_q;
   logic              rden_q;
   logic              wren_q;
   logic [7:0]        wdata_q;
   logic              done_q;
   logic              err_q;

   logic [ADDR_W-1:0] map_addr;
   logic [2:0]        map_bit;
   logic              map_in_range;
   logic              op_ok;
   logic [7:0]        wdata_d;

   midway8080_vram_addr_map u_addr_map (
      .x_i        (req_x),
      .y_i        (req_y),
      .addr_o     (map_addr),
      .bit_o      (map_bit),
      .in_range_o (map_in_range)
   );

`ifdef MIDWAY8080_VRAM_TOGGLE_EN
   assign op_ok = (req_op != OP_RSV);
`else
   assign op_ok = (req_op == OP_CLR) || (req_op == OP_SET);
`endif

   assign wdata_d = apply_op(mem_rdata, bit_q, op_q);

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         bit_q   <= '0;
         op_q    <= OP_CLR;
         rden_q  <= 1'b0;
         wren_q  <= 1'b0;
         wdata_q <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         rden_q <= 1'b0;
         wren_q <= 1'b0;
         done_q <= 1'b0;
         err_q  <= 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               // A simultaneous request stays pending until the clear finishes.
               if (clear_start) begin
                  state_q <= ST_CLEAR;
                  addr_q  <= '0;
                  wdata_q <= 8'h00;
                  wren_q  <= 1'b1;
               end else if (req_valid) begin
                  addr_q <= map_addr;
                  bit_q  <= map_bit;
                  op_q   <= req_op;
                  if (map_in_range && op_ok) begin
                     state_q <= ST_READ;
                     rden_q  <= 1'b1;
                  end else begin
                     state_q <= ST_REJECT;
                     err_q   <= 1'b1;
                  end
               end
            end
            ST_READ: begin
               state_q <= ST_CAPTURE;
            end
            ST_CAPTURE: begin
               // Read data is valid this cycle only; fold the bit change in now.
               state_q <= ST_WRITE;
               wdata_q <= wdata_d;
               wren_q  <= 1'b1;
               done_q  <= 1'b1;
            end
            ST_WRITE: begin
               state_q <= ST_IDLE;
            end
            ST_REJECT: begin
               state_q <= ST_IDLE;
            end
            ST_CLEAR: begin
               if (addr_q == LAST_ADDR) begin
                  state_q <= ST_IDLE;
               end else begin
                  addr_q <= addr_q + ADDR_W'(1);
                  wren_q <= 1'b1;
                  done_q <= (addr_q == PENULT_ADDR);
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   // Gating the strobes with resetn keeps a reset cycle from ever writing.
   assign mem_rden  = rden_q & resetn;
   assign mem_wren  = wren_q & resetn;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign done      = done_q;
   assign err       = err_q;
   assign busy      = (state_q != ST_IDLE);
   assign req_ready = (state_q == ST_IDLE) && !clear_start;

endmodule

// File: tb/tb_midway8080_vram_pixel_writer.sv
// Self-checking bench: directed scenarios plus randomized pixel traffic against
// a per-cycle expectation schedule derived from pixel-level rules.
module tb_midway8080_vram_pixel_writer;

`ifdef MIDWAY8080_VRAM_TOGGLE_EN
   localparam bit TOG_EN = 1'b1;
`else
   localparam bit TOG_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        resetn;
   logic        req_valid;
   logic        req_ready;
   logic [7:0]  req_x;
   logic [7:0]  req_y;
   logic [1:0]  req_op;
   logic        clear_start;
   logic [12:0] mem_addr;
   logic        mem_rden;
   logic [7:0]  mem_rdata;
   logic        mem_wren;
   logic [7:0]  mem_wdata;
   logic        done;
   logic        err;
   logic        busy;

   always #5 clk = ~clk;

   midway8080_vram_pixel_writer dut (
      .clk         (clk),
      .resetn      (resetn),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_x       (req_x),
      .req_y       (req_y),
      .req_op      (req_op),
      .clear_start (clear_start),
      .mem_addr    (mem_addr),
      .mem_rden    (mem_rden),
      .mem_rdata   (mem_rdata),
      .mem_wren    (mem_wren),
      .mem_wdata   (mem_wdata),
      .done        (done),
      .err         (err),
      .busy        (busy)
   );

   typedef struct packed {
      logic        rden;
      logic        wren;
      logic        done;
      logic        err;
      logic [12:0] addr;
      logic [7:0]  wdata;
   } exp_t;

   exp_t       sched[$];
   logic [7:0] mem_vram [0:8191];
   logic [7:0] ref_vram [0:8191];

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int acc_cnt = 0;
   int acc_cyc = -1;
   int clr_cyc = -1;
   bit chk_en = 1'b0;

   int last_rd_addr = -1, last_rd_cyc = -1;
   int last_wr_addr = -1, last_wr_cyc = -1;
   int last_wr_data = -1;
   int last_done_cyc = -1, last_err_cyc = -1;
   int done_wr_addr = -1;
   int wr_cnt = 0, strobe_cnt = 0, wr_in_rst = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // VRAM behavioural memory: read data appears the cycle after mem_rden.
   initial forever begin
      @(posedge clk);
      if (mem_wren === 1'b1) mem_vram[mem_addr] = mem_wdata;
      if (mem_rden === 1'b1) mem_rdata <= mem_vram[mem_addr];
      else mem_rdata <= 8'($urandom);
   end

   // Reference model: each accepted operation becomes a list of expected cycles.
   initial begin
      exp_t e;
      int a;
      logic [7:0] m;
      logic [7:0] nb;
      bit ok;
      forever begin
         @(posedge clk);
         if (resetn !== 1'b1) begin
            sched.delete();
         end else if (sched.size() != 0) begin
            e = sched.pop_front();
            if (e.wren) ref_vram[e.addr] = e.wdata;
         end else if (clear_start === 1'b1) begin
            for (int i = 0; i < 7168; i++) begin
               e = '0;
               e.wren = 1'b1;
               e.addr = 13'(i);
               e.done = (i == 7167);
               sched.push_back(e);
            end
            clr_cyc = cyc;
         end else if (req_valid === 1'b1) begin
            ok = (int'(req_x) < 224) &&
                 (req_op == 2'd0 || req_op == 2'd1 || (TOG_EN && req_op == 2'd2));
            if (ok) begin
               a = int'(req_x) * 32 + (31 - int'(req_y) / 8);
               m = 8'h80 >> (int'(req_y) % 8);
               case (req_op)
                  2'd0:    nb = ref_vram[a] & ~m;
                  2'd1:    nb = ref_vram[a] | m;
                  default: nb = ref_vram[a] ^ m;
               endcase
               e = '0; e.rden = 1'b1; e.addr = 13'(a);
               sched.push_back(e);
               e = '0;
               sched.push_back(e);
               e = '0; e.wren = 1'b1; e.done = 1'b1; e.addr = 13'(a); e.wdata = nb;
               sched.push_back(e);
            end else begin
               e = '0; e.err = 1'b1;
               sched.push_back(e);
            end
            acc_cyc = cyc;
            acc_cnt++;
         end
         cyc++;
      end
   end

   // Per-cycle compare against the model, plus event logging for directed checks.
   initial forever begin
      exp_t e;
      bit   bz;
      @(negedge clk);
      if (chk_en) begin
         if (sched.size() != 0) begin e = sched[0]; bz = 1'b1; end
         else begin e = '0; bz = 1'b0; end
         if (resetn !== 1'b1) begin e.rden = 1'b0; e.wren = 1'b0; end
         check("rden", 32'(mem_rden), 32'(e.rden));
         check("wren", 32'(mem_wren), 32'(e.wren));
         check("done", 32'(done), 32'(e.done));
         check("err", 32'(err), 32'(e.err));
         check("busy", 32'(busy), 32'(bz));
         check("req_ready", 32'(req_ready), 32'(!bz && !clear_start));
         if (e.rden || e.wren) check("mem_addr", 32'(mem_addr), 32'(e.addr));
         if (e.wren) check("mem_wdata", 32'(mem_wdata), 32'(e.wdata));
         if (mem_rden === 1'b1) begin last_rd_addr = int'(mem_addr); last_rd_cyc = cyc; end
         if (mem_wren === 1'b1) begin
            last_wr_addr = int'(mem_addr); last_wr_data = int'(mem_wdata);
            last_wr_cyc = cyc; wr_cnt++;
            if (done === 1'b1) done_wr_addr = int'(mem_addr);
            if (resetn !== 1'b1) wr_in_rst++;
         end
         if (mem_rden === 1'b1 || mem_wren === 1'b1) strobe_cnt++;
         if (done === 1'b1) last_done_cyc = cyc;
         if (err === 1'b1) last_err_cyc = cyc;
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic poke(input int a, input logic [7:0] v);
      mem_vram[a] = v;
      ref_vram[a] = v;
   endtask

   task automatic pix(input logic [7:0] x, input logic [7:0] y, input logic [1:0] op);
      int n0;
      int g;
      n0 = acc_cnt;
      g = 0;
      req_x = x; req_y = y; req_op = op; req_valid = 1'b1;
      do begin tick(); g++; end while (acc_cnt == n0 && g < 20000);
      check("accept_in_time", 32'(acc_cnt != n0), 32'd1);
      req_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int g;
      g = 0;
      while (sched.size() != 0 && g < 20000) begin tick(); g++; end
      check("idle_busy", 32'(busy), 32'd0);
   endtask

   initial begin
      int t1, t2, s0, w0, c0, n0, g, r, mism;
      logic [7:0] rx;
      resetn = 1'b0; req_valid = 1'b0; clear_start = 1'b0;
      req_x = '0; req_y = '0; req_op = '0;
      for (int i = 0; i < 8192; i++) begin
         mem_vram[i] = 8'($urandom);
         ref_vram[i] = mem_vram[i];
      end
      repeat (2) @(posedge clk);
      #2;
      chk_en = 1'b1;
      @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_strobes", 32'({mem_rden, mem_wren}), 32'd0);
      check("rst_addr", 32'(mem_addr), 32'd0);
      check("rst_wdata", 32'(mem_wdata), 32'd0);
      tick();
      resetn = 1'b1;

      // Set x=10,y=0 on a zero byte.
      poke(351, 8'h00);
      pix(8'd10, 8'd0, 2'b01);
      t1 = acc_cyc;
      wait_idle();
      check("set_rd_addr", 32'(last_rd_addr), 32'd351);
      check("set_rd_cyc", 32'(last_rd_cyc - t1), 32'd1);
      check("set_wr_addr", 32'(last_wr_addr), 32'd351);
      check("set_wr_data", 32'(last_wr_data), 32'h80);
      check("set_wr_cyc", 32'(last_wr_cyc - t1), 32'd3);
      check("set_done_cyc", 32'(last_done_cyc - t1), 32'd3);

      // Clear x=0,y=7 on 0xFF, followed back-to-back by another request.
      poke(31, 8'hFF);
      pix(8'd0, 8'd7, 2'b00);
      t1 = acc_cyc;
      pix(8'd10, 8'd0, 2'b00);
      t2 = acc_cyc;
      check("clr_wr_addr", 32'(last_wr_addr), 32'd31);
      check("clr_wr_data", 32'(last_wr_data), 32'hFE);
      check("b2b_accept", 32'(t2 - t1), 32'd4);
      wait_idle();
      check("clr2_wr_data", 32'(last_wr_data), 32'h00);

      // Toggle x=223,y=255 on 0x01.
      poke(7136, 8'h01);
      s0 = strobe_cnt;
      pix(8'd223, 8'd255, 2'b10);
      t1 = acc_cyc;
      wait_idle();
      if (TOG_EN) begin
         check("tog_wr_addr", 32'(last_wr_addr), 32'd7136);
         check("tog_wr_data", 32'(last_wr_data), 32'h00);
      end else begin
         check("tog_err_cyc", 32'(last_err_cyc - t1), 32'd1);
         check("tog_no_strobe", 32'(strobe_cnt - s0), 32'd0);
      end

      // Out-of-range column.
      s0 = strobe_cnt;
      pix(8'd224, 8'd0, 2'b01);
      t1 = acc_cyc;
      @(negedge clk);
      check("rej_err_t1", 32'(err), 32'd1);
      check("rej_ready_t1", 32'(req_ready), 32'd0);
      @(negedge clk);
      check("rej_ready_t2", 32'(req_ready), 32'd1);
      tick();
      check("rej_err_cyc", 32'(last_err_cyc - t1), 32'd1);
      check("rej_no_strobe", 32'(strobe_cnt - s0), 32'd0);

      // Clear and request together: clear wins, request waits.
      w0 = wr_cnt;
      n0 = acc_cnt;
      req_x = 8'd5; req_y = 8'd9; req_op = 2'b01; req_valid = 1'b1;
      clear_start = 1'b1;
      tick();
      clear_start = 1'b0;
      c0 = clr_cyc;
      g = 0;
      while (acc_cnt == n0 && g < 10000) begin tick(); g++; end
      req_valid = 1'b0;
      check("clr_req_accept", 32'(acc_cnt - n0), 32'd1);
      check("clr_req_accept_cyc", 32'(acc_cyc - c0), 32'd7169);
      check("clr_wr_count", 32'(wr_cnt - w0), 32'd7168);
      check("clr_done_cyc", 32'(last_done_cyc - c0), 32'd7168);
      check("clr_done_addr", 32'(done_wr_addr), 32'd7167);
      wait_idle();
      check("clr_mem_first", 32'(mem_vram[0]), 32'd0);
      check("clr_mem_last", 32'(mem_vram[7167]), 32'd0);
      check("post_clr_pix", 32'(mem_vram[190]), 32'h40);

      // Reset while the clear is at address 100.
      poke(100, 8'h5A);
      poke(99, 8'h33);
      clear_start = 1'b1;
      tick();
      clear_start = 1'b0;
      g = 0;
      while (last_wr_addr != 99 && g < 1000) begin tick(); g++; end
      resetn = 1'b0;
      w0 = wr_cnt;
      tick();
      tick();
      resetn = 1'b1;
      @(negedge clk);
      check("rr_ready", 32'(req_ready), 32'd1);
      check("rr_busy", 32'(busy), 32'd0);
      check("rr_flags", 32'({mem_rden, mem_wren, done, err}), 32'd0);
      check("rr_addr", 32'(mem_addr), 32'd0);
      check("rr_wdata", 32'(mem_wdata), 32'd0);
      tick();
      check("rr_no_writes", 32'(wr_cnt - w0), 32'd0);
      check("rr_mem100", 32'(mem_vram[100]), 32'h5A);
      check("rr_mem99", 32'(mem_vram[99]), 32'h00);

      // Randomized traffic with ignored clear pulses and occasional resets.
      for (int it = 0; it < 400; it++) begin
         repeat ($urandom_range(0, 3)) tick();
         rx = ($urandom_range(0, 9) < 8) ? 8'($urandom_range(0, 223)) : 8'($urandom_range(224, 255));
         pix(rx, 8'($urandom), 2'($urandom));
         r = $urandom_range(0, 19);
         if (r < 5) begin
            clear_start = 1'b1;
            tick();
            clear_start = 1'b0;
         end else if (r == 5) begin
            repeat ($urandom_range(0, 2)) tick();
            resetn = 1'b0;
            repeat ($urandom_range(1, 2)) tick();
            resetn = 1'b1;
         end
      end
      wait_idle();

      mism = 0;
      for (int i = 0; i < 7168; i++) if (mem_vram[i] !== ref_vram[i]) mism++;
      check("vram_final", 32'(mism), 32'd0);
      check("no_write_in_reset", 32'(wr_in_rst), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/midway8080_vram_pixel_writer.md
MIDWAY8080_VRAM_PIXEL_WRITER -- requirements
Module: midway8080_vram_pixel_writer

Interface
REQ-001 SHALL have port clk, input, 1, single system clock; all logic on rising edge.
REQ-002 SHALL have port resetn, input, 1, synchronous active-low reset.
REQ-003 SHALL have port req_valid, input, 1, pixel write request present.
REQ-004 SHALL have port req_ready, output, 1, block accepts a request this cycle.
REQ-005 SHALL have port req_x, input, 8, pixel column, valid range 0..223.
REQ-006 SHALL have port req_y, input, 8, pixel row, 0..255.
REQ-007 SHALL have port req_op, input, 2, operation: 00 clear bit, 01 set bit, 10 toggle bit, 11 reserved.
REQ-008 SHALL have port clear_start, input, 1, request a full-screen clear.
REQ-009 SHALL have port mem_addr, output, 13, VRAM byte address.
REQ-010 SHALL have port mem_rden, output, 1, VRAM read strobe; data returns on the next cycle.
REQ-011 SHALL have port mem_rdata, input, 8, VRAM read data.
REQ-012 SHALL have port mem_wren, output, 1, VRAM write strobe.
REQ-013 SHALL have port mem_wdata, output, 8, VRAM write data.
REQ-014 SHALL have port done, output, 1, one-cycle pulse when a pixel operation completes.
REQ-015 SHALL have port err, output, 1, one-cycle pulse when a request is rejected.
REQ-016 SHALL have port busy, output, 1, high in every state except IDLE.

Function
REQ-017 SHALL map pixel coordinates to memory: byte address {req_x, 5'd31 - req_y[7:3]}; bit index 7 - req_y[2:0]. This mapping is the exact inverse of the display-side reader.
REQ-018 SHALL implement states IDLE, READ, CAPTURE, WRITE, REJECT and CLEAR.
REQ-019 SHALL drive req_ready = (state == IDLE) && !clear_start.
REQ-020 On acceptance in cycle T, the block SHALL latch address, bit index and op, then:
- drive mem_rden=1 in T+1 (READ);
- register mem_rdata in T+2 (CAPTURE);
- drive mem_wren=1 and mem_wdata in T+3 (WRITE), with done=1 in the same cycle;
- return to IDLE in T+4.
REQ-021 SHALL compute mem_wdata from the captured byte with only the indexed bit changed: cleared, set or inverted, according to op.
REQ-022 SHALL reject a request with req_x >= 224 or a reserved op: the request is accepted, no memory access occurs, err=1 in T+1, and the block returns to IDLE in T+2.
REQ-023 SHALL enter CLEAR from IDLE when clear_start=1. When clear_start and req_valid are both high in the same cycle, clear SHALL win and the request SHALL remain pending.
REQ-024 In CLEAR, the block SHALL write 8'h00 to addresses 0..7167, one address per cycle, with mem_wren held high. It SHALL return to IDLE after address 7167, with done=1 on the final write.
REQ-025 SHALL ignore clear_start outside IDLE.
REQ-026 SHALL hold mem_rden and mem_wren mutually exclusive, and never assert either outside its designated state.

Reset
REQ-027 While resetn=0 at a clock edge, the block SHALL go to IDLE and drive mem_addr=0, mem_wdata=0, and mem_rden/mem_wren/done/err/busy=0.
REQ-028 A reset during any state, including mid-CLEAR or mid-read-modify-write, SHALL abort that operation without a write in the reset cycle. VRAM contents left partially cleared are acceptable.
REQ-029 SHALL raise req_ready in the first cycle after resetn returns high.

Configuration
REQ-030 With MIDWAY8080_VRAM_TOGGLE_EN defined, op 10 SHALL invert the indexed bit.
REQ-031 Without MIDWAY8080_VRAM_TOGGLE_EN, op 10 SHALL be treated as reserved and rejected per REQ-022.

Structure
REQ-032 Package midway8080_vram_pkg SHALL hold:
- constants VRAM_BYTES=7168, X_LIMIT=224, ADDR_W=13;
- op code constants;
- the state enum typedef.
REQ-033 Coordinate-to-address mapping SHALL live in combinational sub-module midway8080_vram_addr_map, reusable by the display side.

Verification
REQ-034 Set x=10, y=0, old byte 8'h00 -> read at address 10*32+31=351, write 8'h80 at T+3, done at T+3.
REQ-035 Clear x=0, y=7, old byte 8'hFF -> write 8'hFE at address 31; second request accepted at T+4.
REQ-036 Toggle x=223, y=255, old byte 8'h01 -> write 8'h00 at address 7136; without the macro -> err at T+1 and no memory strobes.
REQ-037 x=224, op=set -> err at T+1, no rden/wren, req_ready back high at T+2.
REQ-038 clear_start and req_valid both high in IDLE -> 7168 consecutive zero writes, addresses 0..7167, done on the last; the pending request is then accepted.
REQ-039 resetn low during CLEAR at address 100 -> no further writes, all outputs 0, req_ready=1 on the cycle after release.
